// File: rtl/dma_stream_arbiter_if.sv
// AXI-Stream bundle of LANES parallel lanes. The arbiter uses it for both sides:
// its source side (LANES = NUM_PORTS) and its DMA sink side (LANES = 1).
interface dma_stream_arbiter_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 128
);
  logic [LANES*DATA_W-1:0] tdata;
  logic [LANES-1:0]        tlast;
  logic [LANES-1:0]        tvalid;
  logic [LANES-1:0]        tready;

  modport master (output tdata, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/dma_stream_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_PORTS 128-bit streams onto one DMA stream.
// Define DMA_ARB_OUTREG_EN to put a 2-entry skid buffer on the m_axis_dma side.
module dma_stream_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  dma_stream_arbiter_if.slave  s_axis,
  dma_stream_arbiter_if.master m_axis_dma,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 overlong
);

  localparam int               DATA_W    = 128;
  localparam int               CNT_W     = 9;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BEATS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [IDX_W-1:0] next_grant;

  logic [DATA_W-1:0] lane_data [NUM_PORTS];
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_last;
  logic              src_ready;
  logic              in_grant;
  logic              beat_acc;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0]     ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    int               pos;
    pick = ptr;
    // Walk from lowest to highest priority so the nearest requester after ptr wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      cand = IDX_W'(pos);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) lane_data[i] = s_axis.tdata[i*DATA_W +: DATA_W];
  end

  assign src_data   = lane_data[grant_idx];
  assign src_valid  = s_axis.tvalid[grant_idx];
  assign src_last   = s_axis.tlast[grant_idx];
  assign in_grant   = (state == S_GRANT);
  assign beat_acc   = in_grant & src_valid & src_ready;
  assign next_grant = rr_pick(s_axis.tvalid, rr_ptr);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s_axis.tready = '0;
    if (in_grant) s_axis.tready[grant_idx] = src_ready;
  end

  // The MAX_BEATS-th accepted beat without tlast; the saturated counter keeps it to one pulse.
  assign overlong = beat_acc & ~src_last & (beat_cnt == CNT_MAX - 1'b1);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= LAST_PORT;
      grant_idx <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && |s_axis.tvalid) begin
            grant_idx <= next_grant;
            beat_cnt  <= '0;
            busy      <= 1'b1;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (beat_acc) begin
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (src_last) begin
              rr_ptr <= grant_idx;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMA_ARB_OUTREG_EN
  // Output register plus one skid slot: sources see only the skid-empty flag,
  // never the sink's tready, and the packet ends when tlast enters the buffer.
  logic              out_valid;
  logic              out_last;
  logic [DATA_W-1:0] out_data;
  logic              skid_valid;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;
  logic              out_free;

  assign src_ready = ~skid_valid;
  assign out_free  = ~out_valid | m_axis_dma.tready[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (out_free) begin
        out_valid  <= skid_valid | beat_acc;
        skid_valid <= 1'b0;
      end else if (beat_acc) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; the valid flags alone qualify its contents.
  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end else if (beat_acc) begin
        out_data <= src_data;
        out_last <= src_last;
      end
    end else if (beat_acc) begin
      skid_data <= src_data;
      skid_last <= src_last;
    end
  end

  always_comb begin
    m_axis_dma.tvalid = out_valid;
    m_axis_dma.tdata  = out_data;
    m_axis_dma.tlast  = out_last;
  end
`else
  assign src_ready = m_axis_dma.tready[0];

  always_comb begin
    m_axis_dma.tvalid = in_grant & src_valid;
    m_axis_dma.tdata  = src_data;
    m_axis_dma.tlast  = src_last;
  end
`endif

endmodule
